// File: rtl/lstm_addr_pkg.sv
// lstm_addr_pkg
//   Shared definitions for the LSTM address sequencer: sequencer state
//   encoding, default address/counter widths, the latched walk
//   configuration record and a saturating decrement helper.
//   No ports (package).

package lstm_addr_pkg;

  localparam int LSTM_ADDR_WIDTH = 12;
  localparam int LSTM_CNT_WIDTH  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Fields still needed after start; base and stop are consumed at start.
  typedef struct packed {
    logic [LSTM_ADDR_WIDTH-1:0] stride;
    logic [LSTM_CNT_WIDTH-1:0]  burst;
    logic [LSTM_CNT_WIDTH-1:0]  pause;
    logic [LSTM_CNT_WIDTH-1:0]  hold;
  } walk_cfg_t;

  // Reload value for a down-counter that must run v cycles (0 treated as 1).
  function automatic logic [LSTM_CNT_WIDTH-1:0] dec_sat(input logic [LSTM_CNT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - LSTM_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/lstm_addr_seq_cnt.sv
// addr_seq_cnt
//   Down-counter with terminal-count flag. tc is high while the count is 0,
//   so loading N-1 gives a period of N enabled cycles.
// Ports:
//   clk, rst_n   clock, async active-low reset (count -> 0)
//   clr          synchronous clear to 0 (highest priority)
//   ld, ld_val   synchronous load
//   en           decrement (holds at 0)
//   tc           count == 0

module addr_seq_cnt
  import lstm_addr_pkg::*;
#(
  parameter int W = LSTM_CNT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (clr)                cnt_q <= '0;
    else if (ld)                 cnt_q <= ld_val;
    else if (en && cnt_q != '0)  cnt_q <= cnt_q - W'(1);
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/lstm_addr_seq.sv
// lstm_addr_seq
//   Runtime-programmable address sequencer for LSTM weight/bias/state/
//   gradient RAMs: burst+pause, hold-per-address and strided walks.
//   Optional macro LSTM_ADDR_REV_EN adds descending walks via cfg_rev.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start, abort, en   walk start pulse, synchronous abort, advance enable
//   cfg_base/stride    first address and per-address increment
//   cfg_stop           number of addresses; cfg_burst/cfg_pause burst gaps
//   cfg_hold           cycles per address (0 and 1 both mean 1)
//   cfg_rev            descending walk (only with LSTM_ADDR_REV_EN)
//   o_addr/o_valid/o_last  address output and qualifiers
//   busy, done         walk in progress, one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start, config not latched
// RUN   | emitting addresses, o_valid follows en
// PAUSE | inter-burst gap, counts cfg_pause enabled cycles
// DONE  | one-cycle done pulse, then IDLE

module lstm_addr_seq
  import lstm_addr_pkg::*;
#(
  parameter int ADDR_WIDTH = LSTM_ADDR_WIDTH,
  parameter int CNT_WIDTH  = LSTM_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic [CNT_WIDTH-1:0]  cfg_stop,
  input  logic [CNT_WIDTH-1:0]  cfg_burst,
  input  logic [CNT_WIDTH-1:0]  cfg_pause,
  input  logic [CNT_WIDTH-1:0]  cfg_hold,
  input  logic                  cfg_rev,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  busy,
  output logic                  done
);

  seq_state_t state_q, state_d;
  walk_cfg_t  cfg_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;

  logic start_acc, step, pause_on;
  logic hold_ld, hold_en, hold_tc;
  logic idx_ld, idx_en, idx_tc;
  logic gap_ld, gap_en, gap_tc;
  logic [CNT_WIDTH-1:0] hold_val, idx_val, gap_val;

  // hold: cycles left on this address; idx: addresses left after this one;
  // gap: addresses left in the burst while in RUN, pause cycles left in PAUSE.
  addr_seq_cnt #(.W(CNT_WIDTH)) u_hold (
    .clk(clk), .rst_n(rst_n), .clr(abort), .ld(hold_ld), .ld_val(hold_val),
    .en(hold_en), .tc(hold_tc)
  );
  addr_seq_cnt #(.W(CNT_WIDTH)) u_idx (
    .clk(clk), .rst_n(rst_n), .clr(abort), .ld(idx_ld), .ld_val(idx_val),
    .en(idx_en), .tc(idx_tc)
  );
  addr_seq_cnt #(.W(CNT_WIDTH)) u_gap (
    .clk(clk), .rst_n(rst_n), .clr(abort), .ld(gap_ld), .ld_val(gap_val),
    .en(gap_en), .tc(gap_tc)
  );

  assign pause_on = (cfg_q.burst != '0) && (cfg_q.pause != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    step      = 1'b0;
    hold_ld   = 1'b0;
    hold_en   = 1'b0;
    hold_val  = '0;
    idx_ld    = 1'b0;
    idx_en    = 1'b0;
    idx_val   = '0;
    gap_ld    = 1'b0;
    gap_en    = 1'b0;
    gap_val   = '0;
    o_valid   = (state_q == ST_RUN) && en;
    o_last    = o_valid && hold_tc && idx_tc;
    busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    done      = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          start_acc = 1'b1;
          hold_ld   = 1'b1;
          hold_val  = dec_sat(cfg_hold);
          idx_ld    = 1'b1;
          idx_val   = dec_sat(cfg_stop);
          gap_ld    = 1'b1;
          gap_val   = dec_sat(cfg_burst);
          state_d   = (cfg_stop == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (en) begin
          if (!hold_tc) begin
            hold_en = 1'b1;
          end else if (idx_tc) begin
            state_d = ST_DONE;
          end else begin
            step     = 1'b1;
            hold_ld  = 1'b1;
            hold_val = dec_sat(cfg_q.hold);
            idx_en   = 1'b1;
            if (pause_on && gap_tc) begin
              state_d = ST_PAUSE;
              gap_ld  = 1'b1;
              gap_val = dec_sat(cfg_q.pause);
            end else if (pause_on) begin
              gap_en = 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (en) begin
          if (gap_tc) begin
            state_d = ST_RUN;
            gap_ld  = 1'b1;
            gap_val = dec_sat(cfg_q.burst);
          end else begin
            gap_en = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort) state_d = ST_IDLE;
  end

`ifdef LSTM_ADDR_REV_EN
  logic rev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rev_q <= 1'b0;
    else if (start_acc) rev_q <= cfg_rev;
  end

  assign addr_nxt = rev_q ? (addr_q - cfg_q.stride) : (addr_q + cfg_q.stride);
`else
  logic unused_cfg_rev;
  assign unused_cfg_rev = cfg_rev;
  assign addr_nxt       = addr_q + cfg_q.stride;
`endif

  // The address advances as the last hold cycle of the previous address is
  // accepted, so it is already settled when RUN resumes after a pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cfg_q  <= '0;
    end else if (abort) begin
      addr_q <= '0;
    end else if (start_acc) begin
      addr_q <= cfg_base;
      cfg_q  <= '{stride: cfg_stride, burst: cfg_burst, pause: cfg_pause, hold: cfg_hold};
    end else if (step) begin
      addr_q <= addr_nxt;
    end
  end

  assign o_addr = addr_q;

endmodule
